m_dram_word_ctrl: RTL and testbench
===================================

M_DRAM_WORD_CTRL -- requirements
Module: m_dram_word_ctrl

Interface
REQ-001 SHALL have parameter RD_TIMEOUT, default 1024: ui_clk cycles allowed in S_RWAIT before a read is aborted.
REQ-002 SHALL use one clock and a synchronous active-high reset, listed first:
- ui_clk  in  1  clock
- ui_clk_sync_rst  in  1  reset
REQ-003 SHALL have the following user-side ports:
- i_req_valid  in  1  request strobe
- o_req_ready  out  1  request accepted when high with i_req_valid
- i_req_we  in  1  1=write, 0=read
- i_req_addr  in  28  byte address; bits [1:0] ignored
- i_req_wdata  in  32  write word
- i_req_be  in  4  byte enables, active-high
- o_rvalid  out  1  one-cycle read response strobe
- o_rdata  out  32  read word
- o_rerr  out  1  read timed out; qualified by o_rvalid
- o_rd_cnt  out  32  completed read count
- o_wr_cnt  out  32  completed write count
REQ-004 SHALL have the following memory-controller-side ports:
- app_addr  out  28
- app_cmd  out  3
- app_en  out  1
- app_rdy  in  1
- app_wdf_data  out  128
- app_wdf_mask  out  16, active-high mask
- app_wdf_wren  out  1
- app_wdf_end  out  1
- app_wdf_rdy  in  1
- app_rd_data  in  128
- app_rd_data_valid  in  1
- app_rd_data_end  in  1, unused
- init_calib_complete  in  1
- app_sr_req, app_ref_req, app_zq_req  out  1 each, tied 0

Function
REQ-005 SHALL implement FSM states S_IDLE, S_WRITE, S_RCMD and S_RWAIT; all app_* outputs and user outputs SHALL be registered.
REQ-006 o_req_ready SHALL equal (state==S_IDLE && init_calib_complete); a request SHALL NOT be accepted while calibration is incomplete.
REQ-007 On acceptance, the block SHALL latch the request and drive the controller interface as follows:
- app_addr = {1'b0, addr[27:4], 3'b000}.
- Lane sel = addr[3:2].
- A write SHALL go to S_WRITE; a read SHALL go to S_RCMD.
REQ-008 In S_WRITE, for the write data path:
- app_wdf_data SHALL carry wdata replicated in all four 32-bit lanes.
- app_wdf_mask SHALL be all 1s except bits [4*sel+3:4*sel] = ~be.
REQ-009 In S_WRITE, for the handshakes:
- app_en=1 and app_cmd=3'b000 SHALL be asserted from the cycle after acceptance until sampled with app_rdy=1.
- app_wdf_wren=app_wdf_end=1 SHALL be asserted independently until sampled with app_wdf_rdy=1.
- Each handshake SHALL be tracked by its own done flag.
- Either handshake may complete first or both in the same cycle.
REQ-010 S_WRITE SHALL exit to S_IDLE the cycle after both done flags are set, and o_wr_cnt SHALL increment once at that point.
REQ-011 S_RCMD SHALL assert app_en=1 and app_cmd=3'b001 until sampled with app_rdy=1, then enter S_RWAIT with the timeout counter cleared.
REQ-012 In S_RWAIT, on app_rd_data_valid=1:
- The block SHALL drive o_rvalid=1, o_rdata=app_rd_data[32*sel+31:32*sel] and o_rerr=0 on the next cycle.
- o_rd_cnt SHALL increment.
- The FSM SHALL return to S_IDLE.
REQ-013 If RD_TIMEOUT cycles elapse in S_RWAIT without valid, the block SHALL:
- pulse o_rvalid=1 with o_rerr=1 and o_rdata=0;
- return to S_IDLE;
- leave o_rd_cnt unchanged.
REQ-014 app_rd_data_valid outside S_RWAIT, including late data after a timeout, SHALL be ignored.
REQ-015 o_rvalid SHALL be a single-cycle pulse, and at most one transaction SHALL be outstanding at any time.
REQ-016 Counters SHALL wrap modulo 2^32 without saturation.
REQ-017 Request inputs SHALL be ignored when o_req_ready=0.

Reset
REQ-018 While ui_clk_sync_rst=1, the block SHALL:
- enter S_IDLE;
- drive app_en, app_wdf_wren, app_wdf_end, o_rvalid and o_rerr to 0;
- set app_cmd=0, app_addr=0, app_wdf_data=0, app_wdf_mask=16'hFFFF, o_rdata=0 and counters to 0;
- clear done flags and the timeout counter.
REQ-019 Reset asserted mid-transaction SHALL abandon that transaction, with no response pulse and no counter update.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Write, calibration incomplete: i_req_valid held -> o_req_ready=0 and no app_en until init_calib_complete=1.
- Write, both ready high: addr=0x0000_0024, wdata=0xDEADBEEF, be=4'hF, app_rdy=app_wdf_rdy=1 -> app_addr=0x0000010, mask=16'hFF0F, app_en and wren high for exactly one cycle, o_wr_cnt=1.
- Write, stalled handshakes: app_wdf_rdy low for 5 cycles and app_rdy low for 2 cycles -> wren held 6 cycles, app_en held 3 cycles, single completion, o_wr_cnt increments once.
- Read: addr=0x0000_003C; responder returns 128'h44444444_33333333_22222222_11111111 -> o_rvalid one cycle after valid, o_rdata=0x44444444, o_rerr=0.
- Read timeout: RD_TIMEOUT=16, no valid -> o_rvalid with o_rerr=1 and o_rdata=0 after 16 cycles; a later stray valid produces no o_rvalid.
- Reset mid-read in S_RWAIT: -> all outputs at reset values, no o_rvalid, next request accepted normally.

Source files
------------

// File: rtl/m_dram_word_ctrl.sv
// 32-bit word front end for a 128-bit DDR user interface: one outstanding
// read or write, write lanes selected by byte mask, reads time out after RD_TIMEOUT.
//
// state   | meaning
// S_IDLE  | ready for a request once calibration is complete
// S_WRITE | write command and write data handshakes in flight
// S_RCMD  | read command presented, waiting for app_rdy
// S_RWAIT | waiting for read data or timeout
module m_dram_word_ctrl #(
    parameter int unsigned RD_TIMEOUT = 1024
) (
    input  logic          ui_clk,
    input  logic          ui_clk_sync_rst,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [27:0]   i_req_addr,
    input  logic [31:0]   i_req_wdata,
    input  logic [3:0]    i_req_be,
    output logic          o_rvalid,
    output logic [31:0]   o_rdata,
    output logic          o_rerr,
    output logic [31:0]   o_rd_cnt,
    output logic [31:0]   o_wr_cnt,
    output logic [27:0]   app_addr,
    output logic [2:0]    app_cmd,
    output logic          app_en,
    input  logic          app_rdy,
    output logic [127:0]  app_wdf_data,
    output logic [15:0]   app_wdf_mask,
    output logic          app_wdf_wren,
    output logic          app_wdf_end,
    input  logic          app_wdf_rdy,
    input  logic [127:0]  app_rd_data,
    input  logic          app_rd_data_valid,
    input  logic          app_rd_data_end,
    input  logic          init_calib_complete,
    output logic          app_sr_req,
    output logic          app_ref_req,
    output logic          app_zq_req
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RCMD, S_RWAIT} state_t;

    localparam logic [31:0] TMO_LAST = 32'(RD_TIMEOUT - 1);
    localparam logic [2:0]  CMD_WR   = 3'b000;
    localparam logic [2:0]  CMD_RD   = 3'b001;

    state_t         state_q, state_d;
    logic [27:0]    app_addr_q, app_addr_d;
    logic [2:0]     app_cmd_q, app_cmd_d;
    logic           app_en_q, app_en_d;
    logic [127:0]   wdf_data_q, wdf_data_d;
    logic [15:0]    wdf_mask_q, wdf_mask_d;
    logic           wdf_wren_q, wdf_wren_d;
    logic           wdf_end_q, wdf_end_d;
    logic           cmd_done_q, cmd_done_d;
    logic           wdf_done_q, wdf_done_d;
    logic [1:0]     sel_q, sel_d;
    logic [31:0]    tmo_q, tmo_d;
    logic           rvalid_q, rvalid_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           rerr_q, rerr_d;
    logic [31:0]    rd_cnt_q, rd_cnt_d;
    logic [31:0]    wr_cnt_q, wr_cnt_d;
    logic           accept;
    logic           tmo_hit;
    logic           unused_inputs;

    assign o_req_ready   = (state_q == S_IDLE) && init_calib_complete;
    assign accept        = i_req_valid && o_req_ready;
    assign tmo_hit       = (tmo_q == TMO_LAST);
    assign unused_inputs = ^{app_rd_data_end, i_req_addr[1:0]};

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            state_q    <= S_IDLE;
            app_addr_q <= '0;
            app_cmd_q  <= '0;
            app_en_q   <= 1'b0;
            wdf_data_q <= '0;
            wdf_mask_q <= 16'hFFFF;
            wdf_wren_q <= 1'b0;
            wdf_end_q  <= 1'b0;
            cmd_done_q <= 1'b0;
            wdf_done_q <= 1'b0;
            sel_q      <= '0;
            tmo_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rerr_q     <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            app_addr_q <= app_addr_d;
            app_cmd_q  <= app_cmd_d;
            app_en_q   <= app_en_d;
            wdf_data_q <= wdf_data_d;
            wdf_mask_q <= wdf_mask_d;
            wdf_wren_q <= wdf_wren_d;
            wdf_end_q  <= wdf_end_d;
            cmd_done_q <= cmd_done_d;
            wdf_done_q <= wdf_done_d;
            sel_q      <= sel_d;
            tmo_q      <= tmo_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rerr_q     <= rerr_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = i_req_we ? S_WRITE : S_RCMD;
            S_WRITE: if (cmd_done_q && wdf_done_q) state_d = S_IDLE;
            S_RCMD:  if (app_rdy) state_d = S_RWAIT;
            S_RWAIT: if (app_rd_data_valid || tmo_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        app_addr_d = app_addr_q;
        app_cmd_d  = app_cmd_q;
        app_en_d   = app_en_q;
        wdf_data_d = wdf_data_q;
        wdf_mask_d = wdf_mask_q;
        wdf_wren_d = wdf_wren_q;
        wdf_end_d  = wdf_end_q;
        cmd_done_d = cmd_done_q;
        wdf_done_d = wdf_done_q;
        sel_d      = sel_q;
        tmo_d      = tmo_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        rerr_d     = 1'b0;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    app_addr_d = {1'b0, i_req_addr[27:4], 3'b000};
                    app_cmd_d  = i_req_we ? CMD_WR : CMD_RD;
                    app_en_d   = 1'b1;
                    sel_d      = i_req_addr[3:2];
                    cmd_done_d = 1'b0;
                    wdf_done_d = 1'b0;
                    if (i_req_we) begin
                        wdf_data_d = {4{i_req_wdata}};
                        wdf_mask_d = 16'hFFFF;
                        wdf_mask_d[{i_req_addr[3:2], 2'b00} +: 4] = ~i_req_be;
                        wdf_wren_d = 1'b1;
                        wdf_end_d  = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // Command and data channels finish independently, in either order.
                if (app_en_q && app_rdy) begin
                    app_en_d   = 1'b0;
                    cmd_done_d = 1'b1;
                end
                if (wdf_wren_q && app_wdf_rdy) begin
                    wdf_wren_d = 1'b0;
                    wdf_end_d  = 1'b0;
                    wdf_done_d = 1'b1;
                end
                if (cmd_done_q && wdf_done_q) begin
                    cmd_done_d = 1'b0;
                    wdf_done_d = 1'b0;
                    wr_cnt_d   = wr_cnt_q + 32'd1;
                end
            end
            S_RCMD: begin
                if (app_rdy) begin
                    app_en_d = 1'b0;
                    tmo_d    = '0;
                end
            end
            S_RWAIT: begin
                if (app_rd_data_valid) begin
                    rvalid_d = 1'b1;
                    rdata_d  = app_rd_data[{sel_q, 5'b00000} +: 32];
                    rd_cnt_d = rd_cnt_q + 32'd1;
                end else if (tmo_hit) begin
                    rvalid_d = 1'b1;
                    rerr_d   = 1'b1;
                    rdata_d  = '0;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            default: ;
        endcase
    end

    assign app_addr     = app_addr_q;
    assign app_cmd      = app_cmd_q;
    assign app_en       = app_en_q;
    assign app_wdf_data = wdf_data_q;
    assign app_wdf_mask = wdf_mask_q;
    assign app_wdf_wren = wdf_wren_q;
    assign app_wdf_end  = wdf_end_q;
    assign o_rvalid     = rvalid_q;
    assign o_rdata      = rdata_q;
    assign o_rerr       = rerr_q;
    assign o_rd_cnt     = rd_cnt_q;
    assign o_wr_cnt     = wr_cnt_q;
    assign app_sr_req   = 1'b0;
    assign app_ref_req  = 1'b0;
    assign app_zq_req   = 1'b0;

endmodule

// File: tb/tb_m_dram_word_ctrl.sv
// Directed bench for m_dram_word_ctrl: calibration gating, fast and stalled
// writes, lane read, read timeout with stray data, and reset during a read.
module tb_m_dram_word_ctrl;

    logic          ui_clk = 1'b0;
    logic          ui_clk_sync_rst;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_we;
    logic [27:0]   i_req_addr;
    logic [31:0]   i_req_wdata;
    logic [3:0]    i_req_be;
    logic          o_rvalid;
    logic [31:0]   o_rdata;
    logic          o_rerr;
    logic [31:0]   o_rd_cnt;
    logic [31:0]   o_wr_cnt;
    logic [27:0]   app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          app_rdy;
    logic [127:0]  app_wdf_data;
    logic [15:0]   app_wdf_mask;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic          app_wdf_rdy;
    logic [127:0]  app_rd_data;
    logic          app_rd_data_valid;
    logic          app_rd_data_end;
    logic          init_calib_complete;
    logic          app_sr_req;
    logic          app_ref_req;
    logic          app_zq_req;

    int checks = 0;
    int errors = 0;

    always #5 ui_clk = ~ui_clk;

    m_dram_word_ctrl #(.RD_TIMEOUT(16)) dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .i_req_valid         (i_req_valid),
        .o_req_ready         (o_req_ready),
        .i_req_we            (i_req_we),
        .i_req_addr          (i_req_addr),
        .i_req_wdata         (i_req_wdata),
        .i_req_be            (i_req_be),
        .o_rvalid            (o_rvalid),
        .o_rdata             (o_rdata),
        .o_rerr              (o_rerr),
        .o_rd_cnt            (o_rd_cnt),
        .o_wr_cnt            (o_wr_cnt),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .init_calib_complete (init_calib_complete),
        .app_sr_req          (app_sr_req),
        .app_ref_req         (app_ref_req),
        .app_zq_req          (app_zq_req)
    );

    task automatic pulse_reset();
        @(negedge ui_clk);
        ui_clk_sync_rst = 1'b1;
        repeat (2) @(negedge ui_clk);
        ui_clk_sync_rst = 1'b0;
    endtask

    task automatic present_req(input logic we, input logic [27:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
        @(negedge ui_clk);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        i_req_be    = be;
    endtask

    task automatic test_reset();
        ui_clk_sync_rst     = 1'b1;
        init_calib_complete = 1'b0;
        repeat (3) @(negedge ui_clk);
        checks++;
        if ({app_en, app_wdf_wren, app_wdf_end, o_rvalid, o_rerr} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 00000",
                     {app_en, app_wdf_wren, app_wdf_end, o_rvalid, o_rerr});
        end
        checks++;
        if (app_cmd !== 3'd0 || app_addr !== 28'd0 || app_wdf_data !== 128'd0) begin
            errors++;
            $display("FAIL reset_cmd_addr_data got cmd=%h addr=%h data=%h exp 0",
                     app_cmd, app_addr, app_wdf_data);
        end
        checks++;
        if (app_wdf_mask !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_mask got %h exp ffff", app_wdf_mask);
        end
        checks++;
        if (o_rdata !== 32'd0 || o_rd_cnt !== 32'd0 || o_wr_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_user got rdata=%h rd=%0d wr=%0d exp 0", o_rdata, o_rd_cnt, o_wr_cnt);
        end
        checks++;
        if ({app_sr_req, app_ref_req, app_zq_req} !== 3'b000) begin
            errors++;
            $display("FAIL reset_tied got %b exp 000", {app_sr_req, app_ref_req, app_zq_req});
        end
        ui_clk_sync_rst = 1'b0;
    endtask

    task automatic test_calib_gate();
        int bad = 0;
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        present_req(1'b1, 28'h24, 32'hDEADBEEF, 4'hF);
        for (int k = 0; k < 5; k++) begin
            @(negedge ui_clk);
            if (o_req_ready !== 1'b0 || app_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL calib_gate got %0d cycles with ready/app_en high exp 0", bad);
        end
        init_calib_complete = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL calib_ready got %b exp 1", o_req_ready);
        end
        @(negedge ui_clk);
        i_req_valid = 1'b0;
        checks++;
        if (app_en !== 1'b1 || app_wdf_wren !== 1'b1) begin
            errors++;
            $display("FAIL calib_accept got en=%b wren=%b exp 1 1", app_en, app_wdf_wren);
        end
        repeat (4) @(negedge ui_clk);
    endtask

    task automatic test_write_fast();
        int en_cyc = 0;
        int wr_cyc = 0;
        pulse_reset();
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        present_req(1'b1, 28'h24, 32'hDEADBEEF, 4'hF);
        @(negedge ui_clk);
        i_req_valid = 1'b0;
        checks++;
        if (app_addr !== 28'h10 || app_cmd !== 3'b000) begin
            errors++;
            $display("FAIL wfast_addr got addr=%h cmd=%b exp 0000010 000", app_addr, app_cmd);
        end
        checks++;
        if (app_wdf_mask !== 16'hFF0F) begin
            errors++;
            $display("FAIL wfast_mask got %h exp ff0f", app_wdf_mask);
        end
        checks++;
        if (app_wdf_data !== {4{32'hDEADBEEF}}) begin
            errors++;
            $display("FAIL wfast_data got %h exp 4x deadbeef", app_wdf_data);
        end
        en_cyc = int'(app_en);
        wr_cyc = int'(app_wdf_wren && app_wdf_end);
        for (int k = 0; k < 6; k++) begin
            @(negedge ui_clk);
            en_cyc += int'(app_en);
            wr_cyc += int'(app_wdf_wren && app_wdf_end);
        end
        checks++;
        if (en_cyc != 1 || wr_cyc != 1) begin
            errors++;
            $display("FAIL wfast_pulses got en=%0d wren=%0d exp 1 1", en_cyc, wr_cyc);
        end
        checks++;
        if (o_wr_cnt !== 32'd1) begin
            errors++;
            $display("FAIL wfast_cnt got %0d exp 1", o_wr_cnt);
        end
    endtask

    task automatic test_write_stall();
        int en_cyc = 0;
        int wr_cyc = 0;
        int steps  = 0;
        logic [31:0] prev;
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b0;
        present_req(1'b1, 28'h28, 32'h12345678, 4'b0101);
        prev = o_wr_cnt;
        for (int k = 1; k <= 12; k++) begin
            @(negedge ui_clk);
            if (k == 1) begin
                i_req_valid = 1'b0;
                checks++;
                if (app_wdf_mask !== 16'hFAFF || app_wdf_data !== {4{32'h12345678}}) begin
                    errors++;
                    $display("FAIL wstall_mask_data got mask=%h data=%h exp faff 4x12345678",
                             app_wdf_mask, app_wdf_data);
                end
            end
            en_cyc += int'(app_en);
            wr_cyc += int'(app_wdf_wren && app_wdf_end);
            if (o_wr_cnt != prev) steps++;
            prev        = o_wr_cnt;
            app_rdy     = (k >= 3);
            app_wdf_rdy = (k >= 6);
        end
        checks++;
        if (wr_cyc != 6) begin
            errors++;
            $display("FAIL wstall_wren got %0d cycles exp 6", wr_cyc);
        end
        checks++;
        if (en_cyc != 3) begin
            errors++;
            $display("FAIL wstall_en got %0d cycles exp 3", en_cyc);
        end
        checks++;
        if (steps != 1 || o_wr_cnt !== 32'd2) begin
            errors++;
            $display("FAIL wstall_cnt got steps=%0d cnt=%0d exp 1 2", steps, o_wr_cnt);
        end
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
    endtask

    task automatic test_read();
        present_req(1'b0, 28'h3C, 32'h0, 4'h0);
        @(negedge ui_clk);
        i_req_valid = 1'b0;
        checks++;
        if (app_en !== 1'b1 || app_cmd !== 3'b001 || app_addr !== 28'h18 || app_wdf_wren !== 1'b0) begin
            errors++;
            $display("FAIL read_cmd got en=%b cmd=%b addr=%h wren=%b exp 1 001 0000018 0",
                     app_en, app_cmd, app_addr, app_wdf_wren);
        end
        @(negedge ui_clk);
        checks++;
        if (app_en !== 1'b0 || o_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL read_wait got en=%b rvalid=%b exp 0 0", app_en, o_rvalid);
        end
        app_rd_data       = 128'h44444444_33333333_22222222_11111111;
        app_rd_data_valid = 1'b1;
        @(negedge ui_clk);
        app_rd_data_valid = 1'b0;
        checks++;
        if (o_rvalid !== 1'b1 || o_rdata !== 32'h44444444 || o_rerr !== 1'b0) begin
            errors++;
            $display("FAIL read_resp got v=%b d=%h e=%b exp 1 44444444 0", o_rvalid, o_rdata, o_rerr);
        end
        checks++;
        if (o_rd_cnt !== 32'd1) begin
            errors++;
            $display("FAIL read_cnt got %0d exp 1", o_rd_cnt);
        end
        @(negedge ui_clk);
        checks++;
        if (o_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL read_pulse got %b exp 0", o_rvalid);
        end
    endtask

    task automatic test_read_timeout();
        int waited = 0;
        int stray  = 0;
        bit seen   = 0;
        present_req(1'b0, 28'h34, 32'h0, 4'h0);
        @(negedge ui_clk);
        i_req_valid = 1'b0;
        for (int m = 0; m < 40 && !seen; m++) begin
            @(negedge ui_clk);
            if (o_rvalid === 1'b1) seen = 1;
            else waited++;
        end
        checks++;
        if (!seen || waited != 16) begin
            errors++;
            $display("FAIL tmo_latency got seen=%0d wait=%0d exp 1 16", seen, waited);
        end
        checks++;
        if (o_rerr !== 1'b1 || o_rdata !== 32'd0 || o_rd_cnt !== 32'd1) begin
            errors++;
            $display("FAIL tmo_resp got e=%b d=%h cnt=%0d exp 1 0 1", o_rerr, o_rdata, o_rd_cnt);
        end
        app_rd_data_valid = 1'b1;
        for (int m = 0; m < 5; m++) begin
            @(negedge ui_clk);
            if (m == 2) app_rd_data_valid = 1'b0;
            stray += int'(o_rvalid);
        end
        checks++;
        if (stray != 0 || o_rd_cnt !== 32'd1) begin
            errors++;
            $display("FAIL tmo_stray got rvalids=%0d cnt=%0d exp 0 1", stray, o_rd_cnt);
        end
    endtask

    task automatic test_reset_mid_read();
        int stray = 0;
        present_req(1'b0, 28'h30, 32'h0, 4'h0);
        @(negedge ui_clk);
        i_req_valid = 1'b0;
        @(negedge ui_clk);
        ui_clk_sync_rst = 1'b1;
        repeat (2) @(negedge ui_clk);
        checks++;
        if (app_en !== 1'b0 || o_rvalid !== 1'b0 || app_addr !== 28'd0 || app_cmd !== 3'd0 ||
            app_wdf_mask !== 16'hFFFF || app_wdf_data !== 128'd0 || o_rdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_outs got en=%b v=%b addr=%h cmd=%b mask=%h d=%h exp reset values",
                     app_en, o_rvalid, app_addr, app_cmd, app_wdf_mask, o_rdata);
        end
        checks++;
        if (o_rd_cnt !== 32'd0 || o_wr_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_cnt got rd=%0d wr=%0d exp 0 0", o_rd_cnt, o_wr_cnt);
        end
        ui_clk_sync_rst = 1'b0;
        for (int m = 0; m < 25; m++) begin
            @(negedge ui_clk);
            app_rd_data_valid = (m == 3);
            stray += int'(o_rvalid);
        end
        app_rd_data_valid = 1'b0;
        checks++;
        if (stray != 0 || o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_quiet got rvalids=%0d ready=%b exp 0 1", stray, o_req_ready);
        end
        present_req(1'b1, 28'h4, 32'hCAFEF00D, 4'b0011);
        @(negedge ui_clk);
        i_req_valid = 1'b0;
        checks++;
        if (app_en !== 1'b1 || app_wdf_mask !== 16'hFFCF || app_addr !== 28'h0) begin
            errors++;
            $display("FAIL rst_mid_next got en=%b mask=%h addr=%h exp 1 ffcf 0000000",
                     app_en, app_wdf_mask, app_addr);
        end
        repeat (4) @(negedge ui_clk);
        checks++;
        if (o_wr_cnt !== 32'd1) begin
            errors++;
            $display("FAIL rst_mid_wcnt got %0d exp 1", o_wr_cnt);
        end
    endtask

    initial begin
        ui_clk_sync_rst     = 1'b1;
        i_req_valid         = 1'b0;
        i_req_we            = 1'b0;
        i_req_addr          = '0;
        i_req_wdata         = '0;
        i_req_be            = '0;
        app_rdy             = 1'b0;
        app_wdf_rdy         = 1'b0;
        app_rd_data         = '0;
        app_rd_data_valid   = 1'b0;
        app_rd_data_end     = 1'b0;
        init_calib_complete = 1'b0;
        test_reset();
        test_calib_gate();
        test_write_fast();
        test_write_stall();
        test_read();
        test_read_timeout();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
